// File: rtl/demux_3b_1to2_reg_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer.
// Optional feature: define DEMUX_COUNT_EN to add per-output transfer counters
// (out0_count/out1_count, CNT_W bits wide, wrapping). Leave undefined to omit
// both the ports and the counter logic.
package demux_3b_1to2_reg_pkg;
  localparam int   DEMUX_WIDTH = 3;     // default payload width (register index)
  localparam int   DEMUX_CNT_W = 8;     // default counter width
  localparam logic SEL_OUT0    = 1'b0;
  localparam logic SEL_OUT1    = 1'b1;
endpackage

// File: rtl/demux_out_slot.sv
// One-entry holding register with valid/ready flow control.
// A load may coincide with a drain, so a slot sustains 1 transfer/cycle.
// With DEMUX_COUNT_EN defined, also counts completed drains (wrapping).
module demux_out_slot
  import demux_3b_1to2_reg_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
`ifdef DEMUX_COUNT_EN
  output logic [CNT_W-1:0] count,
`endif
  output logic             free
);

  // Slot can take new data when empty or being drained this cycle.
  assign free = ~valid | ready;

  // Load wins over drain; drain alone empties the slot but keeps the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX_COUNT_EN
  // Count completed consumer handshakes; wraps naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (reset)              count <= '0;
    else if (valid & ready) count <= count + 1'b1;
  end
`endif

endmodule

// File: rtl/demux_3b_1to2_reg.sv
// Registered 1-to-2 demultiplexer: steers in_data to output in_sel through
// two independent one-entry holding registers (demux_out_slot).
// in_ready depends only on in_sel and the selected slot's state/ready, so a
// stalled consumer never blocks the other output.
// Optional feature: DEMUX_COUNT_EN adds out0_count/out1_count drain counters.
module demux_3b_1to2_reg
  import demux_3b_1to2_reg_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNT_W = DEMUX_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
`ifdef DEMUX_COUNT_EN
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count,
`endif
  input  logic             out1_ready
);

  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]            load;
  logic [NUM_LANES-1:0]            free;
  logic [NUM_LANES-1:0]            rdy;
  logic [NUM_LANES-1:0]            vld;
  logic [NUM_LANES-1:0][WIDTH-1:0] dat;
`ifdef DEMUX_COUNT_EN
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
`endif

  assign rdy      = {out1_ready, out0_ready};
  assign in_ready = (in_sel == SEL_OUT1) ? free[1] : free[0];

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_slot
      // Only the selected slot sees the accepted transfer.
      assign load[i] = in_valid & in_ready & (in_sel == 1'(i));

      demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (load[i]),
        .load_data (in_data),
        .ready     (rdy[i]),
        .valid     (vld[i]),
        .data      (dat[i]),
`ifdef DEMUX_COUNT_EN
        .count     (cnt[i]),
`endif
        .free      (free[i])
      );
    end
  endgenerate

  assign out0_valid = vld[0];
  assign out0_data  = dat[0];
  assign out1_valid = vld[1];
  assign out1_data  = dat[1];
`ifdef DEMUX_COUNT_EN
  assign out0_count = cnt[0];
  assign out1_count = cnt[1];
`endif

endmodule

// File: tb/tb_demux_3b_1to2_reg.sv
// Self-checking bench for demux_3b_1to2_reg: directed scenarios plus random
// traffic, scored against a per-output FIFO-of-pending-transfers model.
module tb_demux_3b_1to2_reg;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_sel, in_ready;
  logic [2:0] in_data;
  logic       out0_valid, out0_ready, out1_valid, out1_ready;
  logic [2:0] out0_data, out1_data;
`ifdef DEMUX_COUNT_EN
  logic [7:0] out0_count, out1_count;
`endif

  demux_3b_1to2_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sel(in_sel), .in_ready(in_ready),
    .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_data(out1_data),
`ifdef DEMUX_COUNT_EN
    .out0_count(out0_count), .out1_count(out1_count),
`endif
    .out1_ready(out1_ready)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: transfers accepted but not yet taken by the consumer, per output,
  // plus the last payload delivered to each output and drain totals.
  logic [2:0] q0[$], q1[$];
  logic [2:0] last0, last1;
  int         drains0, drains1;
  bit         known = 0;

  // One clock cycle: drive inputs, check state from the previous edge and
  // in_ready, then advance the model across the next rising edge.
  task automatic cyc(input logic rst, input logic iv, input logic [2:0] id,
                     input logic is, input logic r0, input logic r1);
    bit exp_rdy, acc, d0, d1;
    reset = rst; in_valid = iv; in_data = id; in_sel = is;
    out0_ready = r0; out1_ready = r1;
    #1;
    exp_rdy = is ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    if (known) begin
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      chk("out0_data",  32'(out0_data),  32'(last0));
      chk("out1_data",  32'(out1_data),  32'(last1));
      chk("in_ready",   32'(in_ready),   32'(exp_rdy));
`ifdef DEMUX_COUNT_EN
      chk("out0_count", 32'(out0_count), 32'(drains0 % 256));
      chk("out1_count", 32'(out1_count), 32'(drains1 % 256));
`endif
    end
    if (rst) begin
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0; drains0 = 0; drains1 = 0;
      known = 1;
    end else if (known) begin
      acc = iv && exp_rdy;
      d0  = q0.size() != 0 && r0;
      d1  = q1.size() != 0 && r1;
      if (d0) begin void'(q0.pop_front()); drains0++; end
      if (d1) begin void'(q1.pop_front()); drains1++; end
      if (acc && !is) begin q0.push_back(id); last0 = id; end
      if (acc &&  is) begin q1.push_back(id); last1 = id; end
    end
    @(negedge clk);
  endtask

  int d1_before;

  initial begin
    @(negedge clk);
    // 1. Reset with traffic presented: nothing may be captured.
    cyc(1, 1, 3'b101, 0, 1, 1);
    cyc(1, 1, 3'b101, 1, 1, 1);
    cyc(0, 0, 3'b000, 0, 0, 0);
    chk("rst_v0", 32'(out0_valid), 0);
    chk("rst_d0", 32'(out0_data),  0);

    // 2. Routing.
    cyc(0, 1, 3'b011, 0, 1, 1);
    chk("route0", 32'(out0_data), 32'h3);
    cyc(0, 1, 3'b110, 1, 1, 1);
    chk("route1", 32'(out1_data), 32'h6);
    cyc(0, 0, 3'b000, 0, 1, 1);

    // 3. Stall isolation: slot 0 holds 010 and stalls; slot 1 still flows.
    cyc(0, 1, 3'b010, 0, 0, 1);
    cyc(0, 1, 3'b100, 0, 0, 1);
    chk("stall_rdy", 32'(in_ready), 0);
    cyc(0, 1, 3'b111, 1, 0, 0);
    chk("stall_d0", 32'(out0_data), 32'h2);
    chk("other_v1", 32'(out1_valid), 1);
    chk("other_d1", 32'(out1_data), 32'h7);
    cyc(0, 0, 3'b000, 0, 1, 1);

    // 4. Back-to-back to slot 1, no bubbles.
    d1_before = drains1;
    for (int k = 0; k < 8; k++) cyc(0, 1, 3'(k), 1, 1, 1);
    cyc(0, 0, 3'b000, 1, 1, 1);
    chk("b2b_drains", 32'(drains1 - d1_before), 8);
    chk("b2b_last", 32'(out1_data), 32'h7);

    // 5. Reset mid-operation with both slots full and stalled.
    cyc(0, 1, 3'b001, 0, 0, 0);
    cyc(0, 1, 3'b010, 1, 0, 0);
    chk("full_v0", 32'(out0_valid), 1);
    chk("full_v1", 32'(out1_valid), 1);
    cyc(1, 0, 3'b000, 0, 0, 0);
    cyc(0, 0, 3'b000, 0, 1, 1);
    chk("mrst_v0", 32'(out0_valid), 0);
    chk("mrst_v1", 32'(out1_valid), 0);

`ifdef DEMUX_COUNT_EN
    // 6. 257 drains on output 0 wrap the counter to 1.
    cyc(1, 0, 3'b000, 0, 1, 1);
    for (int k = 0; k < 257; k++) cyc(0, 1, 3'(k), 0, 1, 1);
    cyc(0, 0, 3'b000, 0, 1, 1);
    chk("wrap_c0", 32'(out0_count), 1);
    chk("wrap_c1", 32'(out1_count), 0);
`endif

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++)
      cyc(($urandom_range(0, 59) == 0), 1'($urandom), 3'($urandom),
          1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    cyc(0, 0, 3'b000, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
